syzygy_dac_waveform_player: RTL and testbench

Arbitrary-waveform playback engine feeding the I/Q inputs of the SYZYGY DAC PHY.
- Host logic loads packed I/Q sample pairs into an internal dual-port buffer.
- A start command plays the first `length` entries once, or continuously in loop mode.
- Between playbacks the outputs hold a mid-scale idle code.

---
 rtl/syzygy_dac_waveform_player.sv | 183 ++++++++++++++++++
 tb/tb_syzygy_dac_waveform_player.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syzygy_dac_waveform_player.sv
// syzygy_dac_waveform_player: plays packed I/Q samples from an internal buffer into the SYZYGY DAC PHY.
// Optional build macro: SYZYGY_DAC_PLAYER_TWOS_COMP_EN inverts the sample MSB at the output register
// (offset-binary buffer content and idle level leave the block as two's complement).
module syzygy_dac_waveform_player #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [11:0] IDLE_CODE = 12'h800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic [ADDR_W:0]   length,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic [15:0]       loop_count,
    output logic [11:0]       data_i,
    output logic [11:0]       data_q
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned SMP_W = 12;
    localparam int unsigned CNT_W = 16;

`ifdef SYZYGY_DAC_PLAYER_TWOS_COMP_EN
    localparam logic [SMP_W-1:0] MSB_FLIP = 12'h800;
`else
    localparam logic [SMP_W-1:0] MSB_FLIP = 12'h000;
`endif

    localparam logic [SMP_W-1:0] OUT_IDLE = IDLE_CODE ^ MSB_FLIP;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [ADDR_W-1:0]  w_rd_addr_nxt;
    logic [ADDR_W-1:0]  r_last;
    logic [ADDR_W-1:0]  w_last_nxt;
    logic               r_loop;
    logic               w_loop_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_drain;
    logic               w_drain_nxt;
    logic [CNT_W-1:0]   r_loop_count;
    logic [CNT_W-1:0]   w_loop_count_nxt;
    logic [CNT_W-1:0]   w_loop_count_inc;
    logic               w_issue;
    logic               r_valid;
    logic [23:0]        r_mem [DEPTH];
    logic [23:0]        r_ram_q;
    logic [SMP_W-1:0]   r_data_i;
    logic [SMP_W-1:0]   r_data_q;

    assign w_loop_count_inc = (r_loop_count == 16'hFFFF) ? r_loop_count : r_loop_count + CNT_W'(1);

    // Next-state and control-register decode for the playback sequencer
    always_comb begin
        w_state_nxt      = r_state;
        w_rd_addr_nxt    = r_rd_addr;
        w_last_nxt       = r_last;
        w_loop_nxt       = r_loop;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_drain_nxt      = r_drain;
        w_loop_count_nxt = r_loop_count;
        w_issue          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !stop && (length != LEN_W'(0))) begin
                    w_last_nxt       = (length > LEN_W'(DEPTH)) ? ADDR_W'(DEPTH - 1)
                                                                : ADDR_W'(length - LEN_W'(1));
                    w_loop_nxt       = loop;
                    w_loop_count_nxt = '0;
                    w_rd_addr_nxt    = '0;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = S_PLAY;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    // address presented this cycle is discarded
                    w_drain_nxt = 1'b0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_issue = 1'b1;
                    if (r_rd_addr == r_last) begin
                        if (r_loop) begin
                            w_rd_addr_nxt    = '0;
                            w_loop_count_nxt = w_loop_count_inc;
                        end else begin
                            w_loop_count_nxt = CNT_W'(1);
                            w_drain_nxt      = 1'b0;
                            w_state_nxt      = S_DRAIN;
                        end
                    end else begin
                        w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_drain_nxt = 1'b1;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state and control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rd_addr    <= '0;
            r_last       <= '0;
            r_loop       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_drain      <= 1'b0;
            r_loop_count <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_last       <= w_last_nxt;
            r_loop       <= w_loop_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_drain      <= w_drain_nxt;
            r_loop_count <= w_loop_count_nxt;
            r_valid      <= w_issue;
        end
    end

    // Sample buffer: synchronous write, registered read-first read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_ram_q <= r_mem[r_rd_addr];
    end

    // Output register: buffer sample when issued in PLAY, idle level otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_i <= OUT_IDLE;
            r_data_q <= OUT_IDLE;
        end else if (r_valid) begin
            r_data_i <= r_ram_q[11:0] ^ MSB_FLIP;
            r_data_q <= r_ram_q[23:12] ^ MSB_FLIP;
        end else begin
            r_data_i <= OUT_IDLE;
            r_data_q <= OUT_IDLE;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign loop_count = r_loop_count;
    assign data_i     = r_data_i;
    assign data_q     = r_data_q;

endmodule

// File: tb/tb_syzygy_dac_waveform_player.sv
// tb_syzygy_dac_waveform_player: vector table, directed multi-cycle sequences and
// randomized traffic checked against a transaction-level playback model.
module tb_syzygy_dac_waveform_player;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [11:0] IDLE   = 12'h800;
`ifdef SYZYGY_DAC_PLAYER_TWOS_COMP_EN
    localparam logic [11:0] FLIP   = 12'h800;
`else
    localparam logic [11:0] FLIP   = 12'h000;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [23:0]       wr_data = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              loop = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              busy;
    logic              done;
    logic [15:0]       loop_count;
    logic [11:0]       data_i;
    logic [11:0]       data_q;

    int n_cmp = 0;
    int n_err = 0;

    syzygy_dac_waveform_player #(
        .ADDR_W    (ADDR_W),
        .IDLE_CODE (IDLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .length     (length),
        .loop       (loop),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .loop_count (loop_count),
        .data_i     (data_i),
        .data_q     (data_q)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        int          due;
        logic [23:0] v;
    } ev_t;

    ev_t         sb[$];
    logic [23:0] shadow [DEPTH];
    int          t = 0;
    bit          m_busy = 0;
    bit          m_iss = 0;
    int          m_c = 0;
    int          m_len = 1;
    bit          m_loop = 0;
    int          m_passes = 0;
    int          m_done_at = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, t, act, req);
        end
    endtask

    // Advance the model by one clock edge using the inputs applied before it.
    task automatic model_edge();
        int pos;
        t++;
        if (reset) begin
            m_busy = 0; m_iss = 0; m_passes = 0; m_done_at = -1;
            sb.delete();
        end else if (m_iss) begin
            pos = m_c % m_len;
            if (stop) begin
                m_iss = 0;
                m_done_at = t + 2;
            end else begin
                sb.push_back('{t + 1, shadow[pos]});
                if (pos == m_len - 1) begin
                    if (m_loop) begin
                        if (m_passes < 65535) m_passes++;
                    end else begin
                        m_passes = 1;
                        m_iss = 0;
                        m_done_at = t + 2;
                    end
                end
                m_c++;
            end
        end else if (m_busy) begin
            if (t == m_done_at) m_busy = 0;
        end else if (start && !stop && length != 0) begin
            m_busy = 1; m_iss = 1; m_c = 0;
            m_len = (int'(length) > DEPTH) ? DEPTH : int'(length);
            m_loop = loop; m_passes = 0;
        end
        if (wr_en) shadow[wr_addr] = wr_data;
    endtask

    // One clock: edge, model update, then compare all outputs 1 time unit later.
    task automatic tick();
        logic [23:0] ev;
        ev_t e;
        @(posedge clk);
        model_edge();
        #1;
        ev = {IDLE, IDLE};
        if (sb.size() > 0 && sb[0].due == t) begin
            e = sb.pop_front();
            ev = e.v;
        end
        chk("m_data_i", 32'(data_i), 32'(ev[11:0] ^ FLIP));
        chk("m_data_q", 32'(data_q), 32'(ev[23:12] ^ FLIP));
        chk("m_busy", 32'(busy), 32'(m_busy));
        chk("m_done", 32'(done), 32'(t == m_done_at));
        chk("m_loop_count", 32'(loop_count), 32'(m_passes));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             st;
        logic             sp;
        logic [LEN_W-1:0] len;
        logic             lp;
        logic [11:0]      ei;
        logic [11:0]      eq;
        logic             eb;
        logic             ed;
        logic [15:0]      elc;
    } vec_t;

    vec_t vt[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog edge=%0d actual=running required=finished", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dcnt;
        int seen;
        int sel;

        vt[0]  = '{1'b1, 1'b0, 11'd4, 1'b0, IDLE,   IDLE,   1'b1, 1'b0, 16'd0};
        vt[1]  = '{1'b0, 1'b0, 11'd4, 1'b0, IDLE,   IDLE,   1'b1, 1'b0, 16'd0};
        vt[2]  = '{1'b0, 1'b0, 11'd4, 1'b0, 12'h001, 12'h010, 1'b1, 1'b0, 16'd0};
        vt[3]  = '{1'b0, 1'b0, 11'd4, 1'b0, 12'h002, 12'h020, 1'b1, 1'b0, 16'd0};
        vt[4]  = '{1'b0, 1'b0, 11'd4, 1'b0, 12'h003, 12'h030, 1'b1, 1'b0, 16'd1};
        vt[5]  = '{1'b0, 1'b0, 11'd4, 1'b0, 12'h004, 12'h040, 1'b1, 1'b0, 16'd1};
        vt[6]  = '{1'b0, 1'b0, 11'd4, 1'b0, IDLE,   IDLE,   1'b0, 1'b1, 16'd1};
        vt[7]  = '{1'b0, 1'b0, 11'd4, 1'b0, IDLE,   IDLE,   1'b0, 1'b0, 16'd1};
        vt[8]  = '{1'b1, 1'b0, 11'd0, 1'b0, IDLE,   IDLE,   1'b0, 1'b0, 16'd1};
        vt[9]  = '{1'b1, 1'b1, 11'd4, 1'b0, IDLE,   IDLE,   1'b0, 1'b0, 16'd1};
        vt[10] = '{1'b0, 1'b0, 11'd4, 1'b0, IDLE,   IDLE,   1'b0, 1'b0, 16'd1};
        vt[11] = '{1'b0, 1'b0, 11'd4, 1'b0, IDLE,   IDLE,   1'b0, 1'b0, 16'd1};

        // reset, then quiet idle
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_i", 32'(data_i), 32'(IDLE ^ FLIP));
            chk("idle_done", 32'(done), 32'd0);
        end
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_lc", 32'(loop_count), 32'd0);

        // fill the buffer, then the known pattern at 0..3
        for (int a = 0; a < int'(DEPTH); a++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = 24'($urandom);
            tick();
        end
        for (int a = 0; a < 4; a++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(a);
            wr_data = {12'(16 * (a + 1)), 12'(a + 1)};
            tick();
        end
        wr_en = 1'b0;

        // one-shot playback and ignored starts
        for (int k = 0; k < 12; k++) begin
            start = vt[k].st; stop = vt[k].sp; length = vt[k].len; loop = vt[k].lp;
            tick();
            chk($sformatf("tbl%0d_i", k), 32'(data_i), 32'(vt[k].ei ^ FLIP));
            chk($sformatf("tbl%0d_q", k), 32'(data_q), 32'(vt[k].eq ^ FLIP));
            chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(vt[k].eb));
            chk($sformatf("tbl%0d_done", k), 32'(done), 32'(vt[k].ed));
            chk($sformatf("tbl%0d_lc", k), 32'(loop_count), 32'(vt[k].elc));
        end
        start = 1'b0; stop = 1'b0;

        // looped playback: three passes, then stop
        start = 1'b1; length = 11'd4; loop = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k >= 2) chk("loop_i", 32'(data_i), 32'(12'(((k - 2) % 4) + 1) ^ FLIP));
        end
        chk("loop_lc3", 32'(loop_count), 32'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_last_i", 32'(data_i), 32'(12'h004 ^ FLIP));
        dcnt = 0;
        for (int k = 14; k <= 20; k++) begin
            tick();
            chk("stop_idle_i", 32'(data_i), 32'(IDLE ^ FLIP));
            if (done) dcnt++;
            if (k == 14) chk("stop_busy14", 32'(busy), 32'd1);
            if (k == 15) begin
                chk("stop_done15", 32'(done), 32'd1);
                chk("stop_busy15", 32'(busy), 32'd0);
            end
        end
        chk("stop_done_cnt", 32'(dcnt), 32'd1);
        chk("stop_lc", 32'(loop_count), 32'd3);

        // write while playing: same-edge write reads old data, later pass sees new
        start = 1'b1; length = 11'd4; loop = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        wr_en = 1'b1; wr_addr = ADDR_W'(2); wr_data = {12'h030, 12'h0AA};
        tick();
        wr_en = 1'b0;
        tick();
        chk("rdfirst_old_i", 32'(data_i), 32'(12'h003 ^ FLIP));
        tick(); tick(); tick();
        tick();
        chk("wr_new_i", 32'(data_i), 32'(12'h0AA ^ FLIP));

        // asynchronous reset mid-pass
        reset = 1'b1;
        #1;
        chk("arst_i", 32'(data_i), 32'(IDLE ^ FLIP));
        chk("arst_q", 32'(data_q), 32'(IDLE ^ FLIP));
        chk("arst_busy", 32'(busy), 32'd0);
        tick();
        chk("arst_lc", 32'(loop_count), 32'd0);
        reset = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) dcnt++;
        end
        chk("arst_no_done", 32'(dcnt), 32'd0);

        // single-entry loop: same sample every cycle, count every cycle
        start = 1'b1; length = 11'd1; loop = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 2) chk("len1_i", 32'(data_i), 32'(12'h001 ^ FLIP));
        end
        chk("len1_lc", 32'(loop_count), 32'd5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && busy; k++) tick();
        chk("len1_end_busy", 32'(busy), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            wr_en = ($urandom_range(0, 9) < 3);
            wr_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
            wr_data = 24'($urandom);
            start = ($urandom_range(0, 9) == 0);
            stop = ($urandom_range(0, 39) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      length = LEN_W'($urandom_range(0, 8));
            else if (sel < 9) length = LEN_W'($urandom_range(0, 40));
            else              length = LEN_W'($urandom);
            loop = 1'($urandom_range(0, 1));
            tick();
            if (done) seen++;
        end
        wr_en = 1'b0; start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int k = 0; k < 2000 && busy; k++) tick();
        chk("rand_end_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
